fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Control sequencer for a time-multiplexed serial FIR: one shared MAC, an external NTAPS-deep sample RAM and coefficient ROM.
//  Accepts one sample per valid/ready handshake, writes it into the circular sample buffer, then walks all taps.
//  Drives sample/coef read addresses and MAC load/accumulate enables, and flags the completed output.
//  Sits between the signal source and the FIR datapath in top_design.
// PARAMETERS
//  NTAPS    16               number of filter taps (>=2, need not be a power of two)
//  NB_DATA  8                sample width
//  NB_ADDR  $clog2(NTAPS)    address width for sample RAM and coefficient ROM
// PORTS
//  clock           in   1        system clock, rising edge
//  i_reset         in   1        asynchronous, active-low reset
//  i_valid         in   1        input sample valid
//  i_sample        in   NB_DATA  input sample
//  i_clear         in   1        request to zero the sample buffer (sampled in IDLE only)
//  o_ready         out  1        block can accept a sample this cycle
//  o_wr_en         out  1        sample RAM write enable
//  o_wr_addr       out  NB_ADDR  sample RAM write address
//  o_wr_data       out  NB_DATA  sample RAM write data
//  o_rd_addr       out  NB_ADDR  sample RAM read address (read latency 1 cycle)
//  o_coef_addr     out  NB_ADDR  coefficient ROM address (read latency 1 cycle)
//  o_mac_en        out  1        MAC operates this cycle
//  o_mac_clr       out  1        with o_mac_en: load product (acc = p) instead of accumulate
//  o_out_valid     out  1        MAC accumulator holds the finished output (1-cycle pulse)
//  o_drop          out  1        registered pulse: a sample was offered while o_ready=0
// BEHAVIOUR
//  Reset: all outputs 0; state=INIT, write pointer wp=0, tap counter k=0. Asserting i_reset mid-operation aborts immediately; no o_out_valid.
//  Outputs are Moore decodes of registered state/counters, except:
//  - o_ready = (state==IDLE) && !i_clear
//  - o_drop is registered
//  States:
//  - INIT (1 cyc) -> CLEAR.
//  - CLEAR (NTAPS cyc): o_wr_en=1, o_wr_addr=k (0..NTAPS-1), o_wr_data=0; on exit wp=0 -> IDLE.
//  - IDLE: i_clear=1 -> CLEAR (wins over i_valid; sample not accepted, no o_drop).
//    Else i_valid=1 -> latch i_sample -> WRITE.
//  - WRITE (1 cyc): o_wr_en=1, o_wr_addr=wp, o_wr_data=latched sample -> MAC, k=0.
//  - MAC (NTAPS cyc): o_rd_addr=(wp-k) mod NTAPS (wp>=k ? wp-k : wp+NTAPS-k), o_coef_addr=k. After k=NTAPS-1 -> DRAIN.
//  - o_mac_en is asserted the cycle after each MAC address (1-cycle read latency): MAC cycles 2..NTAPS, plus DRAIN.
//    o_mac_clr=1 only with the tap-0 enable.
//  - DRAIN (1 cyc): last o_mac_en -> DONE.
//  - DONE (1 cyc): o_out_valid=1; wp <= (wp==NTAPS-1) ? 0 : wp+1 -> IDLE.
//  Latency: accept edge -> o_out_valid high in cycle NTAPS+3. Throughput is 1 sample per NTAPS+4 cycles.
//  i_valid while o_ready=0 (any non-IDLE state): sample ignored, o_drop=1 next cycle; one pulse per offending cycle.
//  i_clear outside IDLE is ignored (not latched).
//  o_wr_data and addresses are 0 whenever their enable is low.
// TESTING (NTAPS=4)
//  1. Release reset -> 1 idle cycle, then wr_en x4 with addr 0,1,2,3 and data 0, then o_ready=1.
//  2. Accept 0x7F with wp=0 -> WRITE addr 0 data 0x7F; rd_addr 0,3,2,1 with coef_addr 0,1,2,3;
//     mac_en 4 cycles, clr on the first only; out_valid 7 cycles after the accept edge.
//  3. 5 back-to-back samples -> write addr 0,1,2,3,0 (wrap); 5th pass rd_addr 0,3,2,1; 5 out_valid pulses.
//  4. Hold i_valid=1 through one pass -> exactly 1 accept per pass; o_drop high in every non-IDLE cycle (+1 registered).
//  5. i_clear=1 and i_valid=1 together in IDLE -> o_ready=0, no o_drop, 4 zero writes;
//     wp=0 afterwards (next write addr 0).
//  6. Assert i_reset during MAC k=2 -> all outputs 0 asynchronously; after release INIT+CLEAR rerun, no o_out_valid.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a time-multiplexed serial FIR (one shared MAC).
// Handshakes samples in, writes the circular sample RAM, walks all taps.
//
// Ports:
//   clock, i_reset      rising-edge clock, async active-low reset
//   i_valid, i_sample   input sample handshake (with o_ready)
//   i_clear             zero the sample buffer (honoured in IDLE only)
//   o_ready             a sample can be accepted this cycle
//   o_wr_en/addr/data   sample RAM write port
//   o_rd_addr           sample RAM read address (1-cycle latency)
//   o_coef_addr         coefficient ROM address (1-cycle latency)
//   o_mac_en, o_mac_clr MAC enable / load-instead-of-accumulate
//   o_out_valid         accumulator holds a finished output
//   o_drop              registered: sample offered while not ready
module fir_tap_sequencer #(
    parameter int NTAPS   = 16,
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = $clog2(NTAPS)
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_sample,
    input  logic               i_clear,
    output logic               o_ready,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic [NB_ADDR-1:0] o_rd_addr,
    output logic [NB_ADDR-1:0] o_coef_addr,
    output logic               o_mac_en,
    output logic               o_mac_clr,
    output logic               o_out_valid,
    output logic               o_drop
);

    typedef enum logic [2:0] {
        S_INIT,
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST  = NB_ADDR'(NTAPS - 1);
    localparam logic [NB_ADDR-1:0] NT_A  = NB_ADDR'(NTAPS);
    localparam logic [NB_ADDR-1:0] ONE_A = NB_ADDR'(1);

    state_t             state;
    state_t             state_nxt;
    logic [NB_ADDR-1:0] k;
    logic [NB_ADDR-1:0] k_nxt;
    logic [NB_ADDR-1:0] wp;
    logic [NB_ADDR-1:0] wp_nxt;
    logic [NB_DATA-1:0] sample_q;
    logic [NB_DATA-1:0] sample_nxt;
    logic               drop_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_INIT;
            k        <= '0;
            wp       <= '0;
            sample_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            wp       <= wp_nxt;
            sample_q <= sample_nxt;
            drop_q   <= i_valid && (state != S_IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        wp_nxt     = wp;
        sample_nxt = sample_q;
        case (state)
            S_INIT: begin
                state_nxt = S_CLEAR;
                k_nxt     = '0;
            end
            S_CLEAR: begin
                if (k == LAST) begin
                    state_nxt = S_IDLE;
                    k_nxt     = '0;
                    wp_nxt    = '0;
                end else begin
                    k_nxt = k + ONE_A;
                end
            end
            S_IDLE: begin
                // clear has priority; the offered sample is simply not taken
                if (i_clear) begin
                    state_nxt = S_CLEAR;
                    k_nxt     = '0;
                end else if (i_valid) begin
                    sample_nxt = i_sample;
                    state_nxt  = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = S_MAC;
                k_nxt     = '0;
            end
            S_MAC: begin
                if (k == LAST) begin
                    state_nxt = S_DRAIN;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + ONE_A;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                wp_nxt    = (wp == LAST) ? '0 : wp + ONE_A;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        o_wr_en     = 1'b0;
        o_wr_addr   = '0;
        o_wr_data   = '0;
        o_rd_addr   = '0;
        o_coef_addr = '0;
        o_mac_en    = 1'b0;
        o_mac_clr   = 1'b0;
        o_out_valid = 1'b0;
        unique case (1'b1)
            (state == S_CLEAR): begin
                o_wr_en   = 1'b1;
                o_wr_addr = k;
            end
            (state == S_WRITE): begin
                o_wr_en   = 1'b1;
                o_wr_addr = wp;
                o_wr_data = sample_q;
            end
            (state == S_MAC): begin
                // wp+NTAPS-k is < NTAPS when wp<k, so modular
                // NB_ADDR arithmetic yields the right address
                o_rd_addr   = (wp >= k) ? wp - k : wp + NT_A - k;
                o_coef_addr = k;
                // MAC trails its address by the 1-cycle read latency
                o_mac_en    = (k != '0);
                o_mac_clr   = (k == ONE_A);
            end
            (state == S_DRAIN): o_mac_en = 1'b1;
            (state == S_DONE):  o_out_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_ready = (state == S_IDLE) && !i_clear;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (NTAPS=4).
// Scoreboard queues filled at stimulus time, drained by a monitor.
module tb_fir_tap_sequencer;

    localparam int NT  = 4;
    localparam int NBD = 8;
    localparam int NBA = 2;

    logic           clock    = 1'b0;
    logic           i_reset  = 1'b0;
    logic           i_valid  = 1'b0;
    logic [NBD-1:0] i_sample = '0;
    logic           i_clear  = 1'b0;
    logic           o_ready;
    logic           o_wr_en;
    logic [NBA-1:0] o_wr_addr;
    logic [NBD-1:0] o_wr_data;
    logic [NBA-1:0] o_rd_addr;
    logic [NBA-1:0] o_coef_addr;
    logic           o_mac_en;
    logic           o_mac_clr;
    logic           o_out_valid;
    logic           o_drop;

    fir_tap_sequencer #(
        .NTAPS  (NT),
        .NB_DATA(NBD),
        .NB_ADDR(NBA)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_sample   (i_sample),
        .i_clear    (i_clear),
        .o_ready    (o_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_addr  (o_rd_addr),
        .o_coef_addr(o_coef_addr),
        .o_mac_en   (o_mac_en),
        .o_mac_clr  (o_mac_clr),
        .o_out_valid(o_out_valid),
        .o_drop     (o_drop)
    );

    always #5 clock = ~clock;

    wire [19:0] all_out = {o_ready, o_wr_en, o_wr_addr, o_wr_data,
                           o_rd_addr, o_coef_addr, o_mac_en, o_mac_clr,
                           o_out_valid, o_drop};

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int drop_cnt = 0;
    int out_cnt  = 0;
    int wp_m     = 0;

    logic [NBA+NBD-1:0] exp_wr[$];
    logic [2*NBA:0]     exp_mac[$];
    int                 exp_out[$];

    logic [NBA-1:0]     prev_rd   = '0;
    logic [NBA-1:0]     prev_coef = '0;
    logic [NBA+NBD-1:0] w_e;
    logic [2*NBA:0]     m_e;
    int                 o_e;

    always @(posedge clock) cyc = cyc + 1;

    // Monitor: pops scoreboard entries as the DUT produces events
    always @(negedge clock) begin
        if (i_reset) begin
            checks++;
            if (o_wr_en) begin
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected cyc=%0d addr=%0d data=%h",
                             cyc, o_wr_addr, o_wr_data);
                end else begin
                    w_e = exp_wr.pop_front();
                    if ({o_wr_addr, o_wr_data} !== w_e) begin
                        errors++;
                        $display("FAIL wr cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                                 cyc, o_wr_addr, o_wr_data, w_e[NBA+NBD-1:NBD], w_e[NBD-1:0]);
                    end
                end
            end else if (o_wr_addr !== '0 || o_wr_data !== '0) begin
                errors++;
                $display("FAIL wr_idle_zero cyc=%0d addr=%0d data=%h exp 0",
                         cyc, o_wr_addr, o_wr_data);
            end
            checks++;
            if (o_mac_en) begin
                if (exp_mac.size() == 0) begin
                    errors++;
                    $display("FAIL mac_unexpected cyc=%0d", cyc);
                end else begin
                    m_e = exp_mac.pop_front();
                    if ({prev_rd, prev_coef, o_mac_clr} !== m_e) begin
                        errors++;
                        $display("FAIL mac cyc=%0d got rd=%0d coef=%0d clr=%b exp rd=%0d coef=%0d clr=%b",
                                 cyc, prev_rd, prev_coef, o_mac_clr,
                                 m_e[2*NBA:NBA+1], m_e[NBA:1], m_e[0]);
                    end
                end
            end else if (o_mac_clr !== 1'b0) begin
                errors++;
                $display("FAIL mac_clr_alone cyc=%0d got 1 exp 0", cyc);
            end
            if (o_out_valid) begin
                out_cnt++;
                checks++;
                if (exp_out.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected cyc=%0d", cyc);
                end else begin
                    o_e = exp_out.pop_front();
                    if (cyc !== o_e) begin
                        errors++;
                        $display("FAIL out_latency got cyc=%0d exp cyc=%0d", cyc, o_e);
                    end
                end
            end
            if (o_drop) drop_cnt++;
        end
        prev_rd   = o_rd_addr;
        prev_coef = o_coef_addr;
    end

    task automatic push_pass(input logic [NBD-1:0] d, input int a);
        exp_wr.push_back({NBA'(wp_m), d});
        for (int k = 0; k < NT; k++)
            exp_mac.push_back({NBA'((wp_m - k + NT) % NT), NBA'(k), (k == 0)});
        exp_out.push_back(a + 6);
        wp_m = (wp_m + 1) % NT;
    endtask

    task automatic push_clear();
        for (int k = 0; k < NT; k++) exp_wr.push_back({NBA'(k), NBD'(0)});
        wp_m = 0;
    endtask

    task automatic send_sample(input logic [NBD-1:0] d, output int a);
        int n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (!o_ready) begin
            errors++;
            $display("FAIL ready_timeout got 0 exp 1 within 50 cycles");
            a = -1;
            return;
        end
        i_valid  = 1'b1;
        i_sample = d;
        a = cyc + 1;
        push_pass(d, a);
        @(posedge clock); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_wr.size() + exp_mac.size() + exp_out.size()) != 0 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if ((exp_wr.size() + exp_mac.size() + exp_out.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain got wr=%0d mac=%0d out=%0d pending exp 0",
                     nm, exp_wr.size(), exp_mac.size(), exp_out.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        push_clear();
        @(posedge clock); #1;
        i_reset = 1'b1;
        @(negedge clock);
        checks++;
        if (o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL init_cycle wr_en got %b exp 0", o_wr_en);
        end
        for (int i = 0; i < NT; i++) begin
            @(negedge clock);
            checks++;
            if (o_wr_en !== 1'b1 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle%0d wr_en=%b ready=%b exp 1,0", i, o_wr_en, o_ready);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (o_ready !== 1'b1 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL reset_ready got ready=%b pend=%0d exp 1,0", o_ready, exp_wr.size());
        end
    endtask

    task automatic test_single();
        int a;
        int o0 = out_cnt;
        send_sample(8'h7F, a);
        wait_drain("single");
        checks++;
        if (out_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL single_outs got %0d exp 1", out_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int prev = 0;
        int o0 = out_cnt;
        for (int i = 0; i < 5; i++) begin
            send_sample(NBD'(8'h10 + i), a);
            if (i > 0) begin
                checks++;
                if (a - prev !== NT + 4) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d exp %0d", i, a - prev, NT + 4);
                end
            end
            prev = a;
        end
        wait_drain("b2b");
        checks++;
        if (out_cnt - o0 !== 5) begin
            errors++;
            $display("FAIL b2b_outs got %0d exp 5", out_cnt - o0);
        end
    endtask

    task automatic test_hold_valid();
        int d0 = drop_cnt;
        i_valid  = 1'b1;
        i_sample = 8'hC3;
        push_pass(8'hC3, cyc + 1);
        for (int i = 0; i < NT + 3; i++) begin
            @(posedge clock); #1;
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_busy%0d ready got %b exp 0", i, o_ready);
            end
        end
        @(posedge clock); #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_idle ready got %b exp 1", o_ready);
        end
        i_valid = 1'b0;
        wait_drain("hold");
        repeat (2) @(negedge clock);
        checks++;
        if (drop_cnt - d0 !== NT + 3) begin
            errors++;
            $display("FAIL hold_drops got %0d exp %0d", drop_cnt - d0, NT + 3);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_clear();
        int a;
        int d0 = drop_cnt;
        i_clear = 1'b1;
        i_valid = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready got %b exp 0", o_ready);
        end
        push_clear();
        @(posedge clock); #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        wait_drain("clear");
        repeat (2) @(negedge clock);
        checks++;
        if (drop_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL clear_drops got %0d exp 0", drop_cnt - d0);
        end
        @(posedge clock); #1;
        send_sample(8'h5A, a);
        wait_drain("clear_after");
    endtask

    task automatic test_abort();
        int a;
        int o0;
        send_sample(8'h33, a);
        repeat (3) @(posedge clock);
        #2;
        o0 = out_cnt;
        i_reset = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL abort_async got %h exp 0", all_out);
        end
        exp_wr.delete();
        exp_mac.delete();
        exp_out.delete();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL abort_hold got %h exp 0", all_out);
        end
        push_clear();
        i_reset = 1'b1;
        @(negedge clock);
        checks++;
        if (o_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_init wr_en got %b exp 0", o_wr_en);
        end
        wait_drain("abort_clear");
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (out_cnt !== o0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_out got outs=%0d ready=%b exp outs=%0d ready=1",
                     out_cnt, o_ready, o0);
        end
        send_sample(8'h11, a);
        wait_drain("abort_after");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_clear();
        test_abort();
        checks++;
        if ((exp_wr.size() + exp_mac.size() + exp_out.size()) != 0) begin
            errors++;
            $display("FAIL final_queues got %0d pending exp 0",
                     exp_wr.size() + exp_mac.size() + exp_out.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
